matrix_mem_rxc: RTL and testbench
=================================

MATRIX_MEM_RXC -- requirements
Module: matrix_mem_rxc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, element width in bits.
REQ-002 SHALL have parameter ROWS, default 10, row count (1..2^ADDR_WIDTH).
REQ-003 SHALL have parameter COLS, default 10, column count (1..2^ADDR_WIDTH).
REQ-004 SHALL have parameter ADDR_WIDTH, default 4, width of rowAddr/colAddr.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 en_ReadMat  input  1  single-element read request.
REQ-008 en_WriteMat  input  1  single-element write request.
REQ-009 en_StreamRow  input  1  stream-row request; streams row rowAddr.
REQ-010 clearMat  input  1  whole-matrix clear request.
REQ-011 rowAddr  input  ADDR_WIDTH  row index.
REQ-012 colAddr  input  ADDR_WIDTH  column index.
REQ-013 writeData  input  DATA_WIDTH  write element.
REQ-014 readData  output  DATA_WIDTH  read/stream element, registered.
REQ-015 readValid  output  1  readData valid this cycle.
REQ-016 readLast  output  1  final element of a row stream.
REQ-017 addrErr  output  1  one-cycle pulse: request rejected for out-of-range address.
REQ-018 busy  output  1  clear or stream in progress; all requests ignored.

Function
REQ-019 SHALL implement FSM states IDLE, STREAM, CLEAR; requests sampled only in IDLE.
REQ-020 IDLE priority SHALL be clearMat > en_StreamRow > single read/write.
REQ-021 Write: en_WriteMat=1, en_ReadMat=0, rowAddr<ROWS, colAddr<COLS -> M[row][col]<=writeData at that edge.
REQ-022 Read: en_ReadMat=1, en_WriteMat=0, in range -> readData=M[row][col], readValid=1, next cycle (latency 1).
REQ-023 en_ReadMat=en_WriteMat=1 simultaneously SHALL be a no-op, no addrErr.
REQ-024 Out-of-range single read/write or stream rowAddr>=ROWS SHALL leave memory unchanged, readValid=0, addrErr=1 next cycle.
REQ-025 Read after write to same address in consecutive cycles SHALL return new data.
REQ-026 Stream accept -> STREAM; readData=M[row][0..COLS-1] on COLS consecutive cycles from next cycle, readValid=1 each, readLast=1 only on column COLS-1; then IDLE.
REQ-027 busy SHALL be 1 every cycle the FSM is in STREAM or CLEAR, 0 in IDLE.
REQ-028 readData SHALL hold last value when readValid=0.
REQ-029 Column counter SHALL span exactly 0..COLS-1, no wrap beyond.

Reset
REQ-030 rst_n low SHALL immediately force readData=0, readValid=0, readLast=0, addrErr=0, busy=0, FSM=IDLE, counters=0.
REQ-031 Memory contents SHALL NOT be reset.
REQ-032 Reset mid-stream or mid-clear SHALL abort; partially cleared contents retained; no completion outputs.

Configuration
REQ-033 Macro MATRIX_CLEAR_EN defined: clearMat accepted in IDLE -> CLEAR, writes 0 row-major one element/cycle, ROWS*COLS cycles, then IDLE.
REQ-034 MATRIX_CLEAR_EN undefined: CLEAR state absent, clearMat ignored, memory never bulk-cleared.

Verification
REQ-035 Defaults; write 0xA5 to (3,7), read (3,7) -> next cycle readData=0xA5, readValid=1.
REQ-036 Write rows 2 cols 0..9 with 0x10..0x19, stream row 2 -> 10 cycles readData 0x10..0x19, busy=1, readLast only with 0x19.
REQ-037 Write (10,0) and read (0,12) -> addrErr pulse each, (0,0) content unchanged, readValid=0.
REQ-038 MATRIX_CLEAR_EN: fill all 0xFF, pulse clearMat -> busy 100 cycles, requests during busy ignored; then read (9,9) -> 0x00.
REQ-039 Assert rst_n low on stream cycle 4 -> outputs 0 immediately, IDLE; matrix contents intact on subsequent read.
REQ-040 en_ReadMat=en_WriteMat=1 on (1,1) with 0x33 -> no write, readValid=0, addrErr=0.

Source files
------------

// File: rtl/matrix_mem_rxc.sv
// ROWS x COLS matrix store with single-element read/write, whole-row streaming
// and an optional bulk clear (enabled by defining MATRIX_CLEAR_EN).
module matrix_mem_rxc #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 10,
    parameter int COLS       = 10,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_ReadMat,
    input  logic                  en_WriteMat,
    input  logic                  en_StreamRow,
    input  logic                  clearMat,
    input  logic [ADDR_WIDTH-1:0] rowAddr,
    input  logic [ADDR_WIDTH-1:0] colAddr,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData,
    output logic                  readValid,
    output logic                  readLast,
    output logic                  addrErr,
    output logic                  busy
);

    localparam int DEPTH = ROWS * COLS;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM
`ifdef MATRIX_CLEAR_EN
        , CLEAR
`endif
    } state_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_row;
    logic [ADDR_WIDTH-1:0] r_col;

    logic                  w_row_ok;
    logic                  w_col_ok;
    logic                  w_clr_req;
    logic                  w_single;
    logic                  w_rd_req;
    logic                  w_wr_req;
    logic [IDX_W-1:0]      w_rc_idx;
    logic [IDX_W-1:0]      w_row0_idx;
    logic [IDX_W-1:0]      w_str_idx;
    logic                  w_we;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [DATA_WIDTH-1:0] w_wr_data;

`ifdef MATRIX_CLEAR_EN
    logic [IDX_W-1:0]      r_clr_cnt;
    assign w_clr_req = clearMat;
`else
    logic                  w_unused;
    assign w_unused  = clearMat;
    assign w_clr_req = 1'b0;
`endif

    assign w_row_ok   = (int'(rowAddr) < ROWS);
    assign w_col_ok   = (int'(colAddr) < COLS);
    assign w_single   = !w_clr_req && !en_StreamRow;
    assign w_rd_req   = w_single && en_ReadMat && !en_WriteMat;
    assign w_wr_req   = w_single && en_WriteMat && !en_ReadMat;

    // Row-major flat indices; only used once the address is known to be in range.
    assign w_rc_idx   = IDX_W'(int'(rowAddr) * COLS + int'(colAddr));
    assign w_row0_idx = IDX_W'(int'(rowAddr) * COLS);
    assign w_str_idx  = IDX_W'(int'(r_row) * COLS + int'(r_col));

    always_comb begin
        w_we      = rst_n && (r_state == IDLE) && w_wr_req && w_row_ok && w_col_ok;
        w_wr_idx  = w_rc_idx;
        w_wr_data = writeData;
`ifdef MATRIX_CLEAR_EN
        if (r_state == CLEAR) begin
            w_we      = rst_n;
            w_wr_idx  = r_clr_cnt;
            w_wr_data = '0;
        end
`endif
    end

    // Storage is deliberately left out of reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_wr_idx] <= w_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_row     <= '0;
            r_col     <= '0;
            readData  <= '0;
            readValid <= 1'b0;
            readLast  <= 1'b0;
            addrErr   <= 1'b0;
            busy      <= 1'b0;
`ifdef MATRIX_CLEAR_EN
            r_clr_cnt <= '0;
`endif
        end else begin
            readValid <= 1'b0;
            readLast  <= 1'b0;
            addrErr   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_clr_req) begin
`ifdef MATRIX_CLEAR_EN
                        r_state   <= CLEAR;
                        r_clr_cnt <= '0;
                        busy      <= 1'b1;
`endif
                    end else if (en_StreamRow) begin
                        if (w_row_ok) begin
                            // Element 0 goes out on the accept edge; the rest follow in STREAM.
                            r_state   <= STREAM;
                            r_row     <= rowAddr;
                            r_col     <= (COLS == 1) ? '0 : ADDR_WIDTH'(1);
                            readData  <= r_mem[w_row0_idx];
                            readValid <= 1'b1;
                            readLast  <= (COLS == 1);
                            busy      <= 1'b1;
                        end else begin
                            addrErr <= 1'b1;
                        end
                    end else if (w_rd_req || w_wr_req) begin
                        if (w_row_ok && w_col_ok) begin
                            if (w_rd_req) begin
                                readData  <= r_mem[w_rc_idx];
                                readValid <= 1'b1;
                            end
                        end else begin
                            addrErr <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (readLast) begin
                        r_state <= IDLE;
                        r_col   <= '0;
                        busy    <= 1'b0;
                    end else begin
                        readData  <= r_mem[w_str_idx];
                        readValid <= 1'b1;
                        readLast  <= (r_col == ADDR_WIDTH'(COLS - 1));
                        r_col     <= (r_col == ADDR_WIDTH'(COLS - 1)) ? '0 : r_col + 1'b1;
                    end
                end
`ifdef MATRIX_CLEAR_EN
                CLEAR: begin
                    if (r_clr_cnt == IDX_W'(DEPTH - 1)) begin
                        r_state   <= IDLE;
                        r_clr_cnt <= '0;
                        busy      <= 1'b0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mem_rxc.sv
// Randomized self-checking bench for matrix_mem_rxc against a plain 2-D array model.
module tb_matrix_mem_rxc;

    localparam int DW   = 8;
    localparam int ROWS = 10;
    localparam int COLS = 10;
    localparam int AW   = 4;
`ifdef MATRIX_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en_ReadMat, en_WriteMat, en_StreamRow, clearMat;
    logic [AW-1:0] rowAddr, colAddr;
    logic [DW-1:0] writeData;
    logic [DW-1:0] readData;
    logic          readValid, readLast, addrErr, busy;

    logic [DW-1:0] model [ROWS][COLS];
    logic [DW-1:0] exp_rd;
    int            total = 0;
    int            bad   = 0;

    always #5 clk = ~clk;

    matrix_mem_rxc #(
        .DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .en_ReadMat(en_ReadMat), .en_WriteMat(en_WriteMat),
        .en_StreamRow(en_StreamRow), .clearMat(clearMat),
        .rowAddr(rowAddr), .colAddr(colAddr), .writeData(writeData),
        .readData(readData), .readValid(readValid), .readLast(readLast),
        .addrErr(addrErr), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit clr, input bit strm, input bit rd, input bit wr,
                         input int row, input int col, input logic [DW-1:0] data);
        clearMat     = clr;
        en_StreamRow = strm;
        en_ReadMat   = rd;
        en_WriteMat  = wr;
        rowAddr      = AW'(row);
        colAddr      = AW'(col);
        writeData    = data;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, '0);
    endtask

    // Requests presented while busy; the model ignores them entirely.
    task automatic drive_noise();
        drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1), DW'($urandom));
    endtask

    task automatic apply_op(input bit clr, input bit strm, input bit rd, input bit wr,
                            input int row, input int col, input logic [DW-1:0] data);
        bit rok = (row < ROWS);
        bit cok = (col < COLS);
        $display("op clr=%0b str=%0b rd=%0b wr=%0b row=%0d col=%0d data=%02h",
                 clr, strm, rd, wr, row, col, data);
        drive(clr, strm, rd, wr, row, col, data);
        tick();
        if (strm) begin
            if (rok) begin
                for (int c = 0; c < COLS; c++) begin
                    if (c > 0) begin
                        drive_noise();
                        tick();
                    end
                    exp_rd = model[row][c];
                    chk("str_data", readData, exp_rd);
                    chk("str_valid", readValid, 1);
                    chk("str_last", readLast, (c == COLS - 1));
                    chk("str_busy", busy, 1);
                    chk("str_err", addrErr, 0);
                end
                drive_noise();
                tick();
                chk("str_end_busy", busy, 0);
                chk("str_end_valid", readValid, 0);
                chk("str_end_last", readLast, 0);
                chk("str_end_data", readData, exp_rd);
            end else begin
                chk("str_oor_err", addrErr, 1);
                chk("str_oor_valid", readValid, 0);
                chk("str_oor_busy", busy, 0);
                chk("str_oor_data", readData, exp_rd);
            end
        end else begin
            if (rd && wr) begin
                chk("rw_err", addrErr, 0);
                chk("rw_valid", readValid, 0);
            end else if (rd) begin
                if (rok && cok) begin
                    exp_rd = model[row][col];
                    chk("rd_valid", readValid, 1);
                    chk("rd_err", addrErr, 0);
                end else begin
                    chk("rd_oor_err", addrErr, 1);
                    chk("rd_oor_valid", readValid, 0);
                end
            end else if (wr) begin
                if (rok && cok) begin
                    model[row][col] = data;
                    chk("wr_err", addrErr, 0);
                end else begin
                    chk("wr_oor_err", addrErr, 1);
                end
                chk("wr_valid", readValid, 0);
            end else begin
                chk("nop_valid", readValid, 0);
                chk("nop_err", addrErr, 0);
            end
            chk("data", readData, exp_rd);
            chk("last", readLast, 0);
            chk("busy", busy, 0);
        end
        drive_idle();
    endtask

    initial begin
        exp_rd = '0;
        rst_n  = 1'b0;
        drive_idle();
        #12;
        chk("rst_data", readData, 0);
        chk("rst_valid", readValid, 0);
        chk("rst_last", readLast, 0);
        chk("rst_err", addrErr, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                apply_op(1'b0, 1'b0, 1'b0, 1'b1, r, c, DW'($urandom));

        apply_op(1'b0, 1'b0, 1'b0, 1'b1, 3, 7, 8'hA5);
        apply_op(1'b0, 1'b0, 1'b1, 1'b0, 3, 7, '0);
        chk("a5_read", readData, 8'hA5);

        for (int c = 0; c < COLS; c++)
            apply_op(1'b0, 1'b0, 1'b0, 1'b1, 2, c, DW'(8'h10 + c));
        apply_op(1'b0, 1'b1, 1'b0, 1'b0, 2, 0, '0);
        chk("row2_lastval", readData, 8'h19);

        apply_op(1'b0, 1'b0, 1'b0, 1'b1, 10, 0, 8'h5A);
        apply_op(1'b0, 1'b0, 1'b1, 1'b0, 0, 12, '0);
        apply_op(1'b0, 1'b1, 1'b0, 1'b0, 12, 0, '0);
        apply_op(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, '0);

        apply_op(1'b0, 1'b0, 1'b1, 1'b1, 1, 1, 8'h33);
        apply_op(1'b0, 1'b0, 1'b1, 1'b0, 1, 1, '0);

        // Reset on the fourth stream cycle: outputs drop at once, memory survives.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2, 0, '0);
        tick();
        drive_idle();
        tick();
        tick();
        tick();
        chk("pre_rst_data", readData, 8'h13);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", readData, 0);
        chk("mid_rst_valid", readValid, 0);
        chk("mid_rst_last", readLast, 0);
        chk("mid_rst_busy", busy, 0);
        exp_rd = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_valid", readValid, 0);
        apply_op(1'b0, 1'b0, 1'b1, 1'b0, 2, 5, '0);
        apply_op(1'b0, 1'b0, 1'b1, 1'b0, 3, 7, '0);

        if (CLR_EN) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    apply_op(1'b0, 1'b0, 1'b0, 1'b1, r, c, 8'hFF);
            drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, '0);
            tick();
            for (int i = 0; i < ROWS * COLS; i++) begin
                chk("clr_busy", busy, 1);
                chk("clr_valid", readValid, 0);
                drive(1'b0, 1'b0, 1'b0, 1'b1,
                      $urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1), 8'h77);
                tick();
            end
            drive_idle();
            chk("clr_done_busy", busy, 0);
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    model[r][c] = '0;
            apply_op(1'b0, 1'b0, 1'b1, 1'b0, 9, 9, '0);
            chk("clr_read99", readData, 0);
            apply_op(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, '0);
        end else begin
            apply_op(1'b1, 1'b0, 1'b0, 1'b1, 4, 4, 8'h6C);
            apply_op(1'b0, 1'b0, 1'b1, 1'b0, 4, 4, '0);
            chk("noclr_read", readData, 8'h6C);
        end

        for (int n = 0; n < 250; n++) begin
            int  kind = $urandom_range(0, 9);
            bit  clr  = CLR_EN ? 1'b0 : 1'($urandom);
            int  row  = $urandom_range(0, 11);
            int  col  = $urandom_range(0, 11);
            logic [DW-1:0] d = DW'($urandom);
            case (kind)
                0, 1, 2, 3: apply_op(clr, 1'b0, 1'b1, 1'b0, row, col, d);
                4, 5, 6:    apply_op(clr, 1'b0, 1'b0, 1'b1, row, col, d);
                7:          apply_op(clr, 1'b1, 1'($urandom), 1'($urandom), row, col, d);
                8:          apply_op(clr, 1'b0, 1'b1, 1'b1, row, col, d);
                default:    apply_op(clr, 1'b0, 1'b0, 1'b0, row, col, d);
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
